// File: rtl/aes_round_sequencer.sv
// Control FSM sequencing the AES-128 datapath: load 8 words, initial ARK, 10 rounds, drain 8 words.
// Optional on-the-fly key expansion step before each round: define AES_SEQ_KEYEXP_EN.
module aes_round_sequencer (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       start_i,
    output logic       ready_o,
    output logic       stall_o,
    input  logic       word_valid_i,
    output logic       load_we_o,
    output logic [2:0] load_idx_o,
    output logic       init_ark_o,
    output logic       round_en_o,
    output logic [3:0] round_idx_o,
    output logic       final_round_o,
    output logic       key_exp_en_o,
    output logic       rd_valid_o,
    output logic [2:0] rd_idx_o,
    input  logic       rd_ready_i,
    output logic       done_o
);

    localparam int unsigned WORD_IDX_W = 3;
    localparam int unsigned ROUND_W    = 4;
    localparam logic [WORD_IDX_W-1:0] LAST_WORD  = WORD_IDX_W'(7);
    localparam logic [ROUND_W-1:0]    LAST_ROUND = ROUND_W'(10);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
`ifdef AES_SEQ_KEYEXP_EN
        , S_KEYEXP = 3'd6
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_IDX_W-1:0] word_q, word_d;
    logic [ROUND_W-1:0]    round_q, round_d;
    logic                  round_last;

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            round_q <= round_d;
        end
    end

    // Any out-of-range round count is treated as the last round so the FSM always drains
    assign round_last = (round_q >= LAST_ROUND);

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    word_d  = '0;
                end
            end
            S_LOAD: begin
                if (word_valid_i) begin
                    word_d = word_q + 1'b1;
                    if (word_q == LAST_WORD) state_d = S_INIT;
                end
            end
            S_INIT: begin
                round_d = ROUND_W'(1);
`ifdef AES_SEQ_KEYEXP_EN
                state_d = S_KEYEXP;
`else
                state_d = S_ROUND;
`endif
            end
`ifdef AES_SEQ_KEYEXP_EN
            S_KEYEXP: state_d = S_ROUND;
`endif
            S_ROUND: begin
                if (round_last) begin
                    state_d = S_DRAIN;
                    word_d  = '0;
                end else begin
                    round_d = round_q + 1'b1;
`ifdef AES_SEQ_KEYEXP_EN
                    state_d = S_KEYEXP;
`else
                    state_d = S_ROUND;
`endif
                end
            end
            S_DRAIN: begin
                if (rd_ready_i) begin
                    word_d = word_q + 1'b1;
                    if (word_q == LAST_WORD) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready_o       = 1'b0;
        load_we_o     = 1'b0;
        load_idx_o    = '0;
        init_ark_o    = 1'b0;
        round_en_o    = 1'b0;
        round_idx_o   = '0;
        final_round_o = 1'b0;
        key_exp_en_o  = 1'b0;
        rd_valid_o    = 1'b0;
        rd_idx_o      = '0;
        done_o        = 1'b0;
        case (state_q)
            S_IDLE:  ready_o = 1'b1;
            S_LOAD: begin
                load_we_o  = word_valid_i;
                load_idx_o = word_q;
            end
            S_INIT:  init_ark_o = 1'b1;
`ifdef AES_SEQ_KEYEXP_EN
            S_KEYEXP: begin
                key_exp_en_o = 1'b1;
                round_idx_o  = round_q;
            end
`endif
            S_ROUND: begin
                round_en_o    = 1'b1;
                round_idx_o   = round_q;
                final_round_o = (round_q == LAST_ROUND);
            end
            S_DRAIN: begin
                rd_valid_o = 1'b1;
                rd_idx_o   = word_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ready_o = 1'b0;
        endcase
        stall_o = start_i & ~ready_o;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: expected control events are queued per operation
// and compared in order as the DUT raises them; done latency is checked per operation.
module tb_aes_round_sequencer;

    logic       clk_i = 1'b0;
    logic       reset;
    logic       start_i;
    logic       ready_o;
    logic       stall_o;
    logic       word_valid_i;
    logic       load_we_o;
    logic [2:0] load_idx_o;
    logic       init_ark_o;
    logic       round_en_o;
    logic [3:0] round_idx_o;
    logic       final_round_o;
    logic       key_exp_en_o;
    logic       rd_valid_o;
    logic [2:0] rd_idx_o;
    logic       rd_ready_i;
    logic       done_o;

    aes_round_sequencer dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .stall_o      (stall_o),
        .word_valid_i (word_valid_i),
        .load_we_o    (load_we_o),
        .load_idx_o   (load_idx_o),
        .init_ark_o   (init_ark_o),
        .round_en_o   (round_en_o),
        .round_idx_o  (round_idx_o),
        .final_round_o(final_round_o),
        .key_exp_en_o (key_exp_en_o),
        .rd_valid_o   (rd_valid_o),
        .rd_idx_o     (rd_idx_o),
        .rd_ready_i   (rd_ready_i),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef AES_SEQ_KEYEXP_EN
    localparam int BASE_LAT = 38;
`else
    localparam int BASE_LAT = 28;
`endif

    // Event word: {load_we, init, round_en, key_exp, rd_beat, done, load_idx[3], round_idx[4], final, rd_idx[3]}
    typedef logic [16:0] ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  acc_cyc = 0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    bit  done_seen = 1'b0;
    bit  mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int kind, input int idx);
        ev_t e;
        e = '0;
        case (kind)
            0: begin e[16] = 1'b1; e[10:8] = 3'(idx); end
            1: e[15] = 1'b1;
            2: begin e[14] = 1'b1; e[7:4] = 4'(idx); e[3] = (idx == 10); end
            3: begin e[13] = 1'b1; e[7:4] = 4'(idx); end
            4: begin e[12] = 1'b1; e[2:0] = 3'(idx); end
            default: e[11] = 1'b1;
        endcase
        return e;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(0, i));
        exp_q.push_back(mk(1, 0));
        for (int r = 1; r <= 10; r++) begin
`ifdef AES_SEQ_KEYEXP_EN
            exp_q.push_back(mk(3, r));
`endif
            exp_q.push_back(mk(2, r));
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(4, i));
        exp_q.push_back(mk(5, 0));
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: pops expected events in order as the DUT produces them
    always @(negedge clk_i) begin
        ev_t obs;
        ev_t e;
        if (reset) begin
            exp_q.delete();
        end else if (mon_en) begin
            if (start_i && ready_o) acc_cyc = cyc;
            obs = {load_we_o, init_ark_o, round_en_o, key_exp_en_o, rd_valid_o && rd_ready_i, done_o,
                   load_idx_o, round_idx_o, final_round_o, rd_idx_o};
            if (|obs[16:11]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(obs), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event", 32'(obs), 32'(e));
                end
                if (done_o) begin
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                    done_cnt++;
                end
            end else if (rd_valid_o && exp_q.size() > 0) begin
                e = exp_q[0];
                check("rd_idx_hold", 32'(rd_idx_o), 32'(e[2:0]));
            end
        end
    end

    // One operation: start, optional LOAD gaps, optional drain backpressure at word 4, optional held start
    task automatic run_op(input bit alt_wv, input int rr_stall_n, input bit hold_start);
        int lat;
        int k;
        int stall_left;
        int stall_cnt;
        lat = BASE_LAT + (alt_wv ? 8 : 0) + rr_stall_n;
        stall_left = rr_stall_n;
        stall_cnt = 0;
        @(posedge clk_i); #1;
        push_expected();
        start_i = 1'b1;
        word_valid_i = 1'b1;
        rd_ready_i = 1'b1;
        done_seen = 1'b0;
        check("ready_at_start", 32'(ready_o), 32'd1);
        check("stall_at_accept", 32'(stall_o), 32'd0);
        @(negedge clk_i); #1;
        k = 0;
        while (!done_seen && k < 200) begin
            @(posedge clk_i); #1;
            k++;
            start_i = hold_start;
            word_valid_i = alt_wv ? (k % 2 == 0) : 1'b1;
            if (rd_valid_o && rd_idx_o == 3'd4 && stall_left > 0) begin
                rd_ready_i = 1'b0;
                stall_left--;
            end else begin
                rd_ready_i = 1'b1;
            end
            if (stall_o) stall_cnt++;
            @(negedge clk_i); #1;
        end
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
        else check("done_latency", 32'(done_cyc - acc_cyc), 32'(lat));
        if (hold_start) check("stall_cycles", 32'(stall_cnt), 32'(lat));
    endtask

    initial begin
        logic [18:0] idle_exp;
        logic [18:0] outs;
        bit found;
        int prev_done;
        idle_exp = {1'b1, 18'd0};
        reset = 1'b1;
        start_i = 1'b0;
        word_valid_i = 1'b1;
        rd_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            outs = {ready_o, stall_o, load_we_o, load_idx_o, init_ark_o, round_en_o, round_idx_o,
                    final_round_o, key_exp_en_o, rd_valid_o, rd_idx_o, done_o};
            check("reset_outputs", 32'(outs), 32'(idle_exp));
        end
        mon_en = 1'b1;

        run_op(1'b0, 0, 1'b0);
        run_op(1'b1, 0, 1'b0);
        run_op(1'b0, 3, 1'b0);
        run_op(1'b0, 0, 1'b1);
        run_op(1'b0, 0, 1'b0);
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1 check("idle_after_hold", 32'(ready_o), 32'd1);

        // Reset in the middle of round 5
        @(posedge clk_i); #1;
        push_expected();
        start_i = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (round_en_o && round_idx_o == 4'd5) found = 1'b1;
        end
        check("reached_round5", 32'(found), 32'd1);
        prev_done = done_cnt;
        reset = 1'b1;
        @(posedge clk_i); #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_round_en", 32'(round_en_o), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 check("no_done_after_reset", 32'(done_cnt), 32'(prev_done));
        run_op(1'b0, 0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1 check("op_count", 32'(done_cnt), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
